// File: rtl/traffic_light_controller_pkg.sv
// Shared types and constants for the intersection controller.
package traffic_light_controller_pkg;

    typedef enum logic [2:0] {
        MAIN_GRN = 3'd0,
        MAIN_EXT = 3'd1,
        MAIN_YEL = 3'd2,
        WALK     = 3'd3,
        SIDE_GRN = 3'd4,
        SIDE_EXT = 3'd5,
        SIDE_YEL = 3'd6
    } state_t;

    localparam logic [1:0] PARAM_BASE = 2'b00;
    localparam logic [1:0] PARAM_EXT  = 2'b01;
    localparam logic [1:0] PARAM_YEL  = 2'b10;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic [3:0] T_BASE_DEF = 4'd6;
    localparam logic [3:0] T_EXT_DEF  = 4'd3;
    localparam logic [3:0] T_YEL_DEF  = 4'd2;

    // Main-street lamp for a phase; red whenever side or walk owns the junction.
    function automatic logic [2:0] main_lamp(input state_t s);
        case (s)
            MAIN_GRN, MAIN_EXT: main_lamp = GRN;
            MAIN_YEL:           main_lamp = YEL;
            default:            main_lamp = RED;
        endcase
    endfunction

    // Side-street lamp for a phase.
    function automatic logic [2:0] side_lamp(input state_t s);
        case (s)
            SIDE_GRN, SIDE_EXT: side_lamp = GRN;
            SIDE_YEL:           side_lamp = YEL;
            default:            side_lamp = RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_controller_time_parameters.sv
// Programmable interval registers and per-phase interval lookup.
module time_parameters
    import traffic_light_controller_pkg::*;
#(
    parameter logic [3:0] T_BASE_DEFAULT = T_BASE_DEF,
    parameter logic [3:0] T_EXT_DEFAULT  = T_EXT_DEF,
    parameter logic [3:0] T_YEL_DEFAULT  = T_YEL_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_reprogram,
    input  logic [1:0] i_selector,
    input  logic [3:0] i_time_value,
    input  state_t     i_state,
    output logic [3:0] o_interval
);

    logic [3:0] r_t_base;
    logic [3:0] r_t_ext;
    logic [3:0] r_t_yel;
    logic [3:0] w_value;

    // A zero interval would never expire cleanly, so it is stored as one second.
    assign w_value = (i_time_value == 4'd0) ? 4'd1 : i_time_value;

    // Parameter write; selector 11 is a no-op.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_t_base <= T_BASE_DEFAULT;
            r_t_ext  <= T_EXT_DEFAULT;
            r_t_yel  <= T_YEL_DEFAULT;
        end else if (i_reprogram) begin
            case (i_selector)
                PARAM_BASE: r_t_base <= w_value;
                PARAM_EXT:  r_t_ext  <= w_value;
                PARAM_YEL:  r_t_yel  <= w_value;
                default:    ;
            endcase
        end
    end

    // Interval for the requested phase.
    always_comb begin
        case (i_state)
            MAIN_GRN, SIDE_GRN:       o_interval = r_t_base;
            MAIN_EXT, SIDE_EXT, WALK: o_interval = r_t_ext;
            default:                  o_interval = r_t_yel;
        endcase
    end

endmodule

// File: rtl/traffic_light_controller.sv
// Intersection sequencer: phase FSM, walk latch, lamp decode, Timer handshake.
module traffic_light_controller
    import traffic_light_controller_pkg::*;
#(
    parameter logic [3:0] T_BASE_DEFAULT = 4'd6,
    parameter logic [3:0] T_EXT_DEFAULT  = 4'd3,
    parameter logic [3:0] T_YEL_DEFAULT  = 4'd2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sensor,
    input  logic       walk_request,
    input  logic       reprogram,
    input  logic [1:0] time_param_selector,
    input  logic [3:0] time_value,
    input  logic       expired,
    output logic [3:0] value,
    output logic       start_timer,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk_light
);

    state_t     r_state;
    logic       r_restart;
    logic       r_walk_pending;
    logic [3:0] r_value;
    logic       r_start_timer;
    logic [2:0] r_main_light;
    logic [2:0] r_side_light;
    logic       r_walk_light;

    state_t     w_next_state;
    state_t     w_req_state;
    logic [3:0] w_interval;
    logic       w_advance;

    // A restart always reloads the base green; otherwise look up the next phase.
    assign w_req_state = r_restart ? MAIN_GRN : w_next_state;
    // expired coinciding with our own load strobe is stale and ignored.
    assign w_advance   = expired && !r_start_timer;

    time_parameters #(
        .T_BASE_DEFAULT (T_BASE_DEFAULT),
        .T_EXT_DEFAULT  (T_EXT_DEFAULT),
        .T_YEL_DEFAULT  (T_YEL_DEFAULT)
    ) u_time_parameters (
        .clock        (clock),
        .reset        (reset),
        .i_reprogram  (reprogram),
        .i_selector   (time_param_selector),
        .i_time_value (time_value),
        .i_state      (w_req_state),
        .o_interval   (w_interval)
    );

    // Next phase taken on expiry; sensor and walk are only looked at here.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MAIN_GRN: w_next_state = sensor ? MAIN_EXT : MAIN_YEL;
            MAIN_EXT: w_next_state = MAIN_YEL;
            MAIN_YEL: w_next_state = (r_walk_pending || walk_request) ? WALK : SIDE_GRN;
            WALK:     w_next_state = SIDE_GRN;
            SIDE_GRN: w_next_state = sensor ? SIDE_EXT : SIDE_YEL;
            SIDE_EXT: w_next_state = SIDE_YEL;
            SIDE_YEL: w_next_state = MAIN_GRN;
            default:  w_next_state = MAIN_GRN;
        endcase
    end

    // Phase register, walk latch and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= MAIN_GRN;
            r_restart      <= 1'b1;
            r_walk_pending <= 1'b0;
            r_value        <= T_BASE_DEFAULT;
            r_start_timer  <= 1'b0;
            r_main_light   <= GRN;
            r_side_light   <= RED;
            r_walk_light   <= 1'b0;
        end else begin
            r_start_timer <= 1'b0;
            if (walk_request && r_state != WALK)
                r_walk_pending <= 1'b1;
            if (reprogram) begin
                // Lamps hold until the restart strobe so they change with the timer load.
                r_state   <= MAIN_GRN;
                r_restart <= 1'b1;
            end else if (r_restart) begin
                r_restart     <= 1'b0;
                r_start_timer <= 1'b1;
                r_value       <= w_interval;
                r_main_light  <= main_lamp(MAIN_GRN);
                r_side_light  <= side_lamp(MAIN_GRN);
                r_walk_light  <= 1'b0;
            end else if (w_advance) begin
                r_state       <= w_next_state;
                r_start_timer <= 1'b1;
                r_value       <= w_interval;
                r_main_light  <= main_lamp(w_next_state);
                r_side_light  <= side_lamp(w_next_state);
                r_walk_light  <= (w_next_state == WALK);
                if (w_next_state == WALK)
                    r_walk_pending <= 1'b0;
            end
        end
    end

    assign value       = r_value;
    assign start_timer = r_start_timer;
    assign main_light  = r_main_light;
    assign side_light  = r_side_light;
    assign walk_light  = r_walk_light;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Scoreboard bench: stimulus queues the expected timer load, monitor checks each start_timer.
module tb_traffic_light_controller;

    localparam logic [2:0] L_R = 3'b100;
    localparam logic [2:0] L_Y = 3'b010;
    localparam logic [2:0] L_G = 3'b001;

    typedef struct {
        logic [3:0] v;
        logic [2:0] m;
        logic [2:0] s;
        logic       w;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sensor = 1'b0;
    logic       walk_request = 1'b0;
    logic       reprogram = 1'b0;
    logic [1:0] time_param_selector = 2'b11;
    logic [3:0] time_value = 4'd0;
    logic       expired = 1'b0;
    logic [3:0] value;
    logic       start_timer;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk_light;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic done = 1'b0;

    traffic_light_controller dut (
        .clock               (clock),
        .reset               (reset),
        .sensor              (sensor),
        .walk_request        (walk_request),
        .reprogram           (reprogram),
        .time_param_selector (time_param_selector),
        .time_value          (time_value),
        .expired             (expired),
        .value               (value),
        .start_timer         (start_timer),
        .main_light          (main_light),
        .side_light          (side_light),
        .walk_light          (walk_light)
    );

    always #5 clock = ~clock;

    function automatic exp_t mk(input logic [3:0] v, input logic [2:0] m,
                                input logic [2:0] s, input logic w);
        exp_t e;
        e.v = v; e.m = m; e.s = s; e.w = w;
        return e;
    endfunction

    // One timer expiry with the given sensor/walk levels, expecting one load.
    task automatic step(input logic sen, input logic wr, input logic [3:0] v,
                        input logic [2:0] m, input logic [2:0] s, input logic w);
        sb.push_back(mk(v, m, s, w));
        @(negedge clock);
        sensor = sen; walk_request = wr; expired = 1'b1;
        @(negedge clock);
        expired = 1'b0; walk_request = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    // Reprogram pulse (optionally with a coincident expiry); expects a restart load.
    task automatic reprog(input logic [1:0] sel, input logic [3:0] tv, input logic exp,
                          input logic [3:0] v);
        sb.push_back(mk(v, L_G, L_R, 1'b0));
        @(negedge clock);
        reprogram = 1'b1; time_param_selector = sel; time_value = tv; expired = exp;
        @(negedge clock);
        reprogram = 1'b0; time_param_selector = 2'b11; expired = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    // Monitor: every comparison lives here.
    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (reset) begin
            if (cyc > 0) begin
                checks++;
                if ({value, start_timer, main_light, side_light, walk_light} !==
                    {4'd6, 1'b0, L_G, L_R, 1'b0}) begin
                    errors++;
                    $display("FAIL reset_state: got v=%0d st=%b m=%b s=%b w=%b want v=6 st=0 m=001 s=100 w=0",
                             value, start_timer, main_light, side_light, walk_light);
                end
            end
        end else begin
            checks++;
            if (!($onehot(main_light) && $onehot(side_light) &&
                  (main_light == L_R || side_light == L_R))) begin
                errors++;
                $display("FAIL lamp_safety: got m=%b s=%b want one lamp each, one street red",
                         main_light, side_light);
            end
            if (start_timer) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_start: got start_timer=1 v=%0d want no load", value);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if ({value, main_light, side_light, walk_light} !== {e.v, e.m, e.s, e.w}) begin
                        errors++;
                        $display("FAIL phase_load: got v=%0d m=%b s=%b w=%b want v=%0d m=%b s=%b w=%b",
                                 value, main_light, side_light, walk_light, e.v, e.m, e.s, e.w);
                    end
                end
            end
        end
        if (done) begin
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL missing_load: got %0d loads outstanding want 0", sb.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        repeat (2) @(negedge clock);
        // Release: restart load of the base interval.
        sb.push_back(mk(4'd6, L_G, L_R, 1'b0));
        reset = 1'b0;
        repeat (6) @(negedge clock);

        // Plain cycle, no sensor.
        step(1'b0, 1'b0, 4'd2, L_Y, L_R, 1'b0);   // MAIN_YEL
        step(1'b0, 1'b0, 4'd6, L_R, L_G, 1'b0);   // SIDE_GRN
        step(1'b0, 1'b0, 4'd2, L_R, L_Y, 1'b0);   // SIDE_YEL
        step(1'b0, 1'b0, 4'd6, L_G, L_R, 1'b0);   // MAIN_GRN

        // Sensor extends main green.
        step(1'b1, 1'b0, 4'd3, L_G, L_R, 1'b0);   // MAIN_EXT
        step(1'b0, 1'b0, 4'd2, L_Y, L_R, 1'b0);   // MAIN_YEL
        step(1'b0, 1'b0, 4'd6, L_R, L_G, 1'b0);   // SIDE_GRN

        // Walk press during SIDE_GRN, serviced after the next main yellow.
        @(negedge clock); walk_request = 1'b1;
        @(negedge clock); walk_request = 1'b0;
        step(1'b0, 1'b0, 4'd2, L_R, L_Y, 1'b0);   // SIDE_YEL
        step(1'b0, 1'b0, 4'd6, L_G, L_R, 1'b0);   // MAIN_GRN
        step(1'b0, 1'b0, 4'd2, L_Y, L_R, 1'b0);   // MAIN_YEL
        step(1'b0, 1'b0, 4'd3, L_R, L_R, 1'b1);   // WALK
        // Press during WALK is dropped.
        @(negedge clock); walk_request = 1'b1;
        @(negedge clock); walk_request = 1'b0;
        step(1'b0, 1'b0, 4'd6, L_R, L_G, 1'b0);   // SIDE_GRN
        step(1'b0, 1'b0, 4'd2, L_R, L_Y, 1'b0);   // SIDE_YEL
        step(1'b0, 1'b0, 4'd6, L_G, L_R, 1'b0);   // MAIN_GRN
        step(1'b0, 1'b0, 4'd2, L_Y, L_R, 1'b0);   // MAIN_YEL
        step(1'b0, 1'b0, 4'd6, L_R, L_G, 1'b0);   // SIDE_GRN, no walk

        // Side extension, then reprogram base=9 with a coincident expiry.
        step(1'b1, 1'b0, 4'd3, L_R, L_G, 1'b0);   // SIDE_EXT
        sensor = 1'b0;
        reprog(2'b00, 4'd9, 1'b1, 4'd9);          // restart MAIN_GRN, v=9

        // Yellow set to 0 is stored as 1.
        reprog(2'b10, 4'd0, 1'b0, 4'd9);
        step(1'b0, 1'b0, 4'd1, L_Y, L_R, 1'b0);   // MAIN_YEL v=1
        // Selector 11 writes nothing but still restarts.
        reprog(2'b11, 4'd5, 1'b0, 4'd9);
        step(1'b0, 1'b0, 4'd1, L_Y, L_R, 1'b0);   // MAIN_YEL
        step(1'b0, 1'b0, 4'd9, L_R, L_G, 1'b0);   // SIDE_GRN
        step(1'b0, 1'b0, 4'd1, L_R, L_Y, 1'b0);   // SIDE_YEL
        step(1'b0, 1'b0, 4'd9, L_G, L_R, 1'b0);   // MAIN_GRN
        step(1'b0, 1'b0, 4'd1, L_Y, L_R, 1'b0);   // MAIN_YEL
        // Walk arriving in the yellow expiry cycle itself counts.
        step(1'b0, 1'b1, 4'd3, L_R, L_R, 1'b1);   // WALK
        step(1'b0, 1'b0, 4'd9, L_R, L_G, 1'b0);   // SIDE_GRN

        repeat (5) @(negedge clock);
        done = 1'b1;
    end

endmodule
